// File: rtl/mcycle_alu_seq.sv
// Multi-cycle unsigned multiply/divide sequencer. Borrows the shared ALU for its adds and subtracts.
// Each operation runs one iteration per clock for WIDTH clocks.
module mcycle_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALU_SrcA,
  output logic [WIDTH-1:0] ALU_SrcB,
  output logic [3:0]       ALU_Control,
  output logic             ALU_Carry,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic [3:0]       ALU_Flags
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluMov = 4'b1101;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            op_q, op_d;
  // hi holds H (mul) or R (div); lo holds L or Q; opnd holds M or D.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] res1_q, res1_d, res2_q, res2_d;

  logic             alu_c;
  logic [WIDTH-1:0] div_s;
  logic             unused_flags;

  assign alu_c        = ALU_Flags[1];
  assign unused_flags = ^{ALU_Flags[3:2], ALU_Flags[0]};
  assign div_s        = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  assign Result1 = res1_q;
  assign Result2 = res2_q;
  assign Busy    = (state_q == StCompute);
  assign Done    = (state_q == StDone);

  // ALU drive depends only on registered state, never on Start.
  always_comb begin
    ALU_Carry   = 1'b0;
    ALU_Control = AluMov;
    ALU_SrcA    = '0;
    ALU_SrcB    = '0;
    if (state_q == StCompute) begin
      if (op_q) begin
        ALU_Control = AluSub;
        ALU_SrcA    = div_s;
        ALU_SrcB    = opnd_q;
      end else begin
        ALU_Control = AluAdd;
        ALU_SrcA    = hi_q;
        ALU_SrcB    = opnd_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StCompute;
          cnt_d   = '0;
          op_d    = MCycleOp;
          hi_d    = '0;
          lo_d    = MCycleOp ? Operand1 : Operand2;
          opnd_d  = MCycleOp ? Operand2 : Operand1;
        end
      end
      StCompute: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q) begin
          // A set MSB means the shifted remainder is 33 bits wide and always exceeds D.
          if (hi_q[WIDTH-1] | alu_c) begin
            hi_d = ALU_Result;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_s;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else if (lo_q[0]) begin
          {hi_d, lo_d} = {alu_c, ALU_Result, lo_q[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
        if (cnt_q == LastIter) begin
          state_d = StDone;
          res1_d  = lo_d;
          res2_d  = hi_d;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

endmodule

// File: tb/tb_mcycle_alu_seq.sv
// Directed bench for mcycle_alu_seq with a behavioural ARM-style ALU attached.
module tb_mcycle_alu_seq;

  logic        CLK;
  logic        RESETN;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;
  logic [31:0] ALU_SrcA, ALU_SrcB;
  logic [3:0]  ALU_Control;
  logic        ALU_Carry;
  logic [31:0] ALU_Result;
  logic [3:0]  ALU_Flags;

  int tests_run = 0;
  int fails     = 0;
  int carry_bad = 0;

  mcycle_alu_seq #(.WIDTH(32)) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .Start      (Start),
    .MCycleOp   (MCycleOp),
    .Operand1   (Operand1),
    .Operand2   (Operand2),
    .Result1    (Result1),
    .Result2    (Result2),
    .Busy       (Busy),
    .Done       (Done),
    .ALU_SrcA   (ALU_SrcA),
    .ALU_SrcB   (ALU_SrcB),
    .ALU_Control(ALU_Control),
    .ALU_Carry  (ALU_Carry),
    .ALU_Result (ALU_Result),
    .ALU_Flags  (ALU_Flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared ALU: SUB carry is set when no borrow occurs.
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (ALU_Control)
      4'b0000: alu_wide = {1'b0, ALU_SrcA} + {1'b0, ALU_SrcB} + {32'd0, ALU_Carry};
      4'b0001: alu_wide = {1'b0, ALU_SrcA} + {1'b0, ~ALU_SrcB} + 33'd1;
      4'b1101: alu_wide = {1'b0, ALU_SrcB};
      default: alu_wide = '0;
    endcase
    ALU_Result = alu_wide[31:0];
    ALU_Flags  = {alu_wide[31], alu_wide[31:0] == 32'd0, alu_wide[32], 1'b0};
  end

  always @(negedge CLK) if (ALU_Carry !== 1'b0) carry_bad++;

  // Issue one operation and follow it to completion; operands are scrambled after acceptance.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output logic done_end, output logic done_after,
                        output logic [3:0] ctrl);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    @(negedge CLK);
    Start = 1'b0; Operand1 = ~a; Operand2 = ~b; MCycleOp = ~op;
    ctrl = ALU_Control;
    busy_cnt = 0;
    while (Busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      @(negedge CLK);
    end
    done_end = Done;
    @(negedge CLK);
    done_after = Done;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      fails++; $display("FAIL reset_busy_done: got %b/%b want 0/0", Busy, Done);
    end
    tests_run++;
    if (Result1 !== 32'd0 || Result2 !== 32'd0) begin
      fails++; $display("FAIL reset_results: got %h/%h want 0/0", Result1, Result2);
    end
    tests_run++;
    if (ALU_Control !== 4'b1101 || ALU_SrcA !== 32'd0 || ALU_SrcB !== 32'd0) begin
      fails++;
      $display("FAIL reset_alu: got ctl=%b a=%h b=%h want 1101/0/0", ALU_Control, ALU_SrcA,
               ALU_SrcB);
    end
    RESETN = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (Busy !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: Busy got %b want 0", Busy);
    end
  endtask

  task automatic test_mul_small();
    int b; logic de, da; logic [3:0] c;
    run_op(1'b0, 32'd7, 32'd6, b, de, da, c);
    tests_run++;
    if (b != 32) begin fails++; $display("FAIL mul7x6_busy: got %0d cycles want 32", b); end
    tests_run++;
    if (de !== 1'b1 || da !== 1'b0) begin
      fails++; $display("FAIL mul7x6_done_pulse: got %b,%b want 1,0", de, da);
    end
    tests_run++;
    if (c !== 4'b0000) begin fails++; $display("FAIL mul_alu_ctl: got %b want 0000", c); end
    tests_run++;
    if (Result1 !== 32'h2A || Result2 !== 32'h0) begin
      fails++; $display("FAIL mul7x6: got %h_%h want 00000000_0000002a", Result2, Result1);
    end
  endtask

  task automatic test_mul_max();
    int b; logic de, da; logic [3:0] c;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, b, de, da, c);
    tests_run++;
    if (Result1 !== 32'h1 || Result2 !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL mul_max: got %h_%h want fffffffe_00000001", Result2, Result1);
    end
    tests_run++;
    if (carry_bad != 0) begin
      fails++; $display("FAIL alu_carry_zero: got %0d nonzero samples want 0", carry_bad);
    end
  endtask

  task automatic test_div();
    int b; logic de, da; logic [3:0] c;
    run_op(1'b1, 32'd100, 32'd7, b, de, da, c);
    tests_run++;
    if (c !== 4'b0001) begin fails++; $display("FAIL div_alu_ctl: got %b want 0001", c); end
    tests_run++;
    if (Result1 !== 32'd14 || Result2 !== 32'd2) begin
      fails++; $display("FAIL div100_7: got q=%0d r=%0d want q=14 r=2", Result1, Result2);
    end
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, b, de, da, c);
    tests_run++;
    if (Result1 !== 32'd1 || Result2 !== 32'h7FFF_FFFE) begin
      fails++; $display("FAIL div_33bit: got q=%h r=%h want q=00000001 r=7ffffffe", Result1,
                        Result2);
    end
  endtask

  task automatic test_div_zero();
    int b; logic de, da; logic [3:0] c;
    run_op(1'b1, 32'h1234, 32'd0, b, de, da, c);
    tests_run++;
    if (b != 32 || de !== 1'b1) begin
      fails++; $display("FAIL divzero_timing: got busy=%0d done=%b want 32/1", b, de);
    end
    tests_run++;
    if (Result1 !== 32'hFFFF_FFFF || Result2 !== 32'h1234) begin
      fails++; $display("FAIL divzero: got q=%h r=%h want q=ffffffff r=00001234", Result1,
                        Result2);
    end
  endtask

  task automatic test_start_held();
    int cnt;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd10; Operand2 = 32'd20;
    @(negedge CLK);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 40) begin
      Operand1 = 32'd100 + 32'(cnt); Operand2 = 32'd3; MCycleOp = 1'b1;
      cnt++;
      @(negedge CLK);
    end
    tests_run++;
    if (cnt != 32 || Done !== 1'b1) begin
      fails++; $display("FAIL held_first_op: got busy=%0d done=%b want 32/1", cnt, Done);
    end
    tests_run++;
    if (Result1 !== 32'd200 || Result2 !== 32'd0) begin
      fails++; $display("FAIL held_latched_ops: got %h_%h want 0_000000c8", Result2, Result1);
    end
    // Operands now 131 and 3, multiply selected; they apply only at the next acceptance.
    MCycleOp = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      fails++; $display("FAIL held_no_accept_in_done: got busy=%b done=%b want 0/0", Busy, Done);
    end
    @(negedge CLK);
    tests_run++;
    if (Busy !== 1'b1) begin
      fails++; $display("FAIL held_accept_k34: Busy got %b want 1", Busy);
    end
    Start = 1'b0;
    cnt = 0;
    while (Done !== 1'b1 && cnt < 40) begin cnt++; @(negedge CLK); end
    tests_run++;
    if (Done !== 1'b1 || Result1 !== 32'd393) begin
      fails++; $display("FAIL held_second_op: got done=%b r1=%0d want 1/393", Done, Result1);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_op();
    int b; logic de, da; logic [3:0] c;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 1'b1; Operand1 = 32'd1000; Operand2 = 32'd7;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    tests_run++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      fails++; $display("FAIL midreset_flags: got busy=%b done=%b want 0/0", Busy, Done);
    end
    tests_run++;
    if (Result1 !== 32'd0 || Result2 !== 32'd0) begin
      fails++; $display("FAIL midreset_results: got %h/%h want 0/0", Result1, Result2);
    end
    tests_run++;
    if (ALU_Control !== 4'b1101) begin
      fails++; $display("FAIL midreset_alu_ctl: got %b want 1101", ALU_Control);
    end
    run_op(1'b0, 32'd3, 32'd5, b, de, da, c);
    tests_run++;
    if (Result1 !== 32'd15 || Result2 !== 32'd0 || de !== 1'b1) begin
      fails++; $display("FAIL mul3x5_after_reset: got %h_%h done=%b want 0_0000000f/1", Result2,
                        Result1, de);
    end
  endtask

  initial begin
    test_reset();
    test_mul_small();
    test_mul_max();
    test_div();
    test_div_zero();
    test_start_held();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
